// File: rtl/neo_pattern_gen.sv
// Pattern generator for a serial RGB pixel strip: loads one color level per
// handshake, requests a transmission, then waits for the controller before the next frame.
module neo_pattern_gen #(
    parameter int          NUM_PIXELS   = 5,
    parameter int          PIX_W        = 3,
    parameter logic [7:0]  LEVEL_MAX    = 8'h20,
    parameter int          FRAME_REPEAT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [1:0]            mode,
    input  logic [NUM_PIXELS-1:0] enable_mask,
    input  logic                  ready_to_load,
    input  logic                  ready_to_send,
    input  logic                  done_wait,
    output logic [PIX_W-1:0]      pixel_index,
    output logic [1:0]            color_index,
    output logic [7:0]            color_level,
    output logic                  load_color,
    output logic                  send_it,
    output logic [7:0]            phase,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND_REQ, WAIT} state_t;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);
    localparam logic [7:0]       REP_LAST = 8'(FRAME_REPEAT - 1);

    state_t                  state;
    logic [1:0]              mode_r;
    logic [NUM_PIXELS-1:0]   mask_r;
    logic [PIX_W-1:0]        pix;
    logic [1:0]              col;
    logic [7:0]              rep;
    logic [PIX_W-1:0]        chase_pos;
    logic [1:0]              rot_pos;
    logic [1:0]              rot_nxt;
    logic [1:0]              lit_col;
    logic                    frame_done;
    logic                    phase_adv;
    logic                    frame_start;
    logic                    xfer;
    logic [4:0]              breathe;
    logic [7:0]              level;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // chase_pos and rot_pos track phase mod NUM_PIXELS and phase mod 3
    // incrementally, so no divider is needed and the 255->0 wrap stays exact.
    always_comb begin
        frame_done  = (state == WAIT) && done_wait;
        phase_adv   = frame_done && (rep == REP_LAST);
        frame_start = run && ((state == IDLE) || frame_done);
        xfer        = (state == LOAD) && ready_to_load;
        rot_nxt     = rot_pos;
        if (phase_adv)
            rot_nxt = (phase == 8'hFF) ? 2'd0 : inc3(rot_pos);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= 8'd0;
            rep       <= 8'd0;
            pix       <= '0;
            col       <= 2'd0;
            chase_pos <= '0;
            rot_pos   <= 2'd0;
        end else begin
            if (phase_adv) begin
                phase     <= phase + 8'd1;
                chase_pos <= (phase == 8'hFF || chase_pos == LAST_PIX) ? '0 : chase_pos + 1'b1;
                rot_pos   <= rot_nxt;
            end
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state <= LOAD;
                        pix   <= '0;
                        col   <= 2'd0;
                    end
                end
                LOAD: begin
                    if (ready_to_load) begin
                        if (col == 2'd2) begin
                            col <= 2'd0;
                            if (pix == LAST_PIX) begin
                                pix   <= '0;
                                state <= SEND_REQ;
                            end else begin
                                pix <= pix + 1'b1;
                            end
                        end else begin
                            col <= col + 2'd1;
                        end
                    end
                end
                SEND_REQ: begin
                    if (ready_to_send)
                        state <= WAIT;
                end
                WAIT: begin
                    if (done_wait) begin
                        rep <= phase_adv ? 8'd0 : rep + 8'd1;
                        pix <= '0;
                        col <= 2'd0;
                        state <= run ? LOAD : IDLE;
                    end
                end
            endcase
        end
    end

    // Frame configuration and the rotate-mode lit color are pure data.
    always_ff @(posedge clock) begin
        if (frame_start) begin
            mode_r  <= mode;
            mask_r  <= enable_mask;
            lit_col <= rot_nxt;
        end else if (xfer && col == 2'd2) begin
            lit_col <= inc3(lit_col);
        end
    end

    always_comb begin
        breathe = phase[5] ? ~phase[4:0] : phase[4:0];
        level   = 8'd0;
        unique case (mode_r)
            2'd0: level = LEVEL_MAX;
            2'd1: level = (col == 2'd1 && pix == chase_pos) ? LEVEL_MAX : 8'd0;
            2'd2: level = {3'b000, breathe};
            2'd3: level = (col == lit_col) ? LEVEL_MAX : 8'd0;
        endcase
        if (!mask_r[pix])
            level = 8'd0;
    end

    assign load_color  = xfer;
    assign send_it     = (state == SEND_REQ) && ready_to_send;
    assign busy        = (state != IDLE);
    assign pixel_index = xfer ? pix : '0;
    assign color_index = xfer ? col : 2'd0;
    assign color_level = xfer ? level : 8'd0;

endmodule

// File: tb/tb_neo_pattern_gen.sv
// Directed bench for neo_pattern_gen with the default 5-pixel, repeat-4 configuration.
module tb_neo_pattern_gen;

    logic       clock;
    logic       reset;
    logic       run;
    logic [1:0] mode;
    logic [4:0] enable_mask;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       done_wait;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic [7:0] phase;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int mph   = 0;
    int mrep  = 0;
    int lp [0:14];
    int lc [0:14];
    int ll [0:14];
    logic [3:0] stall_pat = 4'b1001;

    neo_pattern_gen dut (
        .clock(clock), .reset(reset), .run(run), .mode(mode),
        .enable_mask(enable_mask), .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send), .done_wait(done_wait),
        .pixel_index(pixel_index), .color_index(color_index),
        .color_level(color_level), .load_color(load_color),
        .send_it(send_it), .phase(phase), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_level(input logic [1:0] m, input logic [4:0] mk,
                                             input int p, input int c, input int phv);
        logic [7:0] pb;
        logic [4:0] t;
        pb = phv[7:0];
        if (!mk[p]) return 8'h00;
        case (m)
            2'd0: return 8'h20;
            2'd1: return (c == 1 && p == phv % 5) ? 8'h20 : 8'h00;
            2'd2: begin
                t = pb[5] ? ~pb[4:0] : pb[4:0];
                return {3'b000, t};
            end
            default: return ((p + phv) % 3 == c) ? 8'h20 : 8'h00;
        endcase
    endfunction

    task automatic model_done();
        mrep++;
        if (mrep == 4) begin
            mrep = 0;
            mph  = (mph + 1) % 256;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mph = 0;
        mrep = 0;
    endtask

    task automatic start_from_idle();
        run = 1'b1;
        @(negedge clock);
        check("start busy", busy, 1);
    endtask

    // Entered with the DUT in LOAD; leaves it in WAIT at a falling edge.
    task automatic do_frame(input bit stall, input logic [1:0] em, input logic [4:0] emk, input bit chg);
        int n;
        n = 0;
        for (int cyc = 0; cyc < 200 && n < 15; cyc++) begin
            ready_to_load = stall ? stall_pat[cyc % 4] : 1'b1;
            #1;
            if (load_color) begin
                lp[n] = int'(pixel_index);
                lc[n] = int'(color_index);
                ll[n] = int'(color_level);
                n++;
                if (chg && n == 7) begin
                    mode = 2'd3;
                    enable_mask = 5'b01110;
                end
            end
            @(negedge clock);
        end
        ready_to_load = 1'b1;
        check("load count", n, 15);
        for (int i = 0; i < n; i++) begin
            check("load pixel", lp[i], i / 3);
            check("load color", lc[i], i % 3);
            check("load level", ll[i], exp_level(em, emk, i / 3, i % 3, mph));
        end
        ready_to_send = 1'b0;
        #1;
        check("send before ready", send_it, 0);
        check("load gated in send_req", load_color, 0);
        check("pixel zero in send_req", pixel_index, 0);
        check("busy in send_req", busy, 1);
        ready_to_send = 1'b1;
        #1;
        check("send pulse", send_it, 1);
        @(negedge clock);
        #1;
        check("send single cycle", send_it, 0);
        check("busy in wait", busy, 1);
        ready_to_send = 1'b0;
        ready_to_load = 1'b0;
        @(negedge clock);
        check("wait holds phase", phase, mph[7:0]);
        check("wait holds busy", busy, 1);
    endtask

    task automatic finish_frame(input bit rn);
        done_wait = 1'b1;
        run = rn;
        model_done();
        @(negedge clock);
        done_wait = 1'b0;
        check("phase after done", phase, mph[7:0]);
        check("busy after done", busy, rn);
    endtask

    // Free-runs k frames with all handshakes high; leaves the DUT in WAIT
    // after the k-th send with that frame's done_wait still pending.
    task automatic fast_frames(input int k);
        int sends;
        sends = 0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        done_wait = 1'b1;
        run = 1'b1;
        for (int cyc = 0; cyc < k * 20 + 40 && sends < k; cyc++) begin
            @(negedge clock);
            if (send_it) sends++;
        end
        ready_to_load = 1'b0;
        done_wait = 1'b0;
        @(negedge clock);
        ready_to_send = 1'b0;
        check("fast send count", sends, k);
        check("fast ends busy", busy, 1);
    endtask

    initial begin
        reset = 1'b1;
        run = 1'b0;
        mode = 2'd0;
        enable_mask = 5'b00000;
        ready_to_load = 1'b0;
        ready_to_send = 1'b0;
        done_wait = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset pixel_index", pixel_index, 0);
        check("reset color_index", color_index, 0);
        check("reset color_level", color_level, 0);
        check("reset load_color", load_color, 0);
        check("reset send_it", send_it, 0);
        check("reset phase", phase, 0);
        check("reset busy", busy, 0);

        // Handshake inputs in IDLE do nothing.
        done_wait = 1'b1;
        ready_to_send = 1'b1;
        ready_to_load = 1'b1;
        #1;
        check("idle send_it", send_it, 0);
        check("idle load_color", load_color, 0);
        @(negedge clock);
        check("idle stays idle", busy, 0);
        check("idle phase", phase, 0);
        done_wait = 1'b0;
        ready_to_send = 1'b0;
        ready_to_load = 1'b0;

        // Static frame; run drops mid-frame but the frame completes.
        mode = 2'd0;
        enable_mask = 5'b10101;
        start_from_idle();
        run = 1'b0;
        do_frame(1'b0, 2'd0, 5'b10101, 1'b0);
        finish_frame(1'b0);

        // Stalled static frame, then chase frames across phases 0..5.
        mode = 2'd0;
        enable_mask = 5'b11011;
        start_from_idle();
        do_frame(1'b1, 2'd0, 5'b11011, 1'b0);
        mode = 2'd1;
        enable_mask = 5'b11111;
        finish_frame(1'b1);
        for (int f = 0; f < 22; f++) begin
            do_frame(1'b0, 2'd1, 5'b11111, 1'b0);
            if (mph == 1) check("chase lit pixel 1", ll[4], 8'h20);
            if (mph == 5) check("chase lit pixel 0 at phase 5", ll[1], 8'h20);
            if (f == 21) mode = 2'd0;
            finish_frame(1'b1);
        end

        // Mode/mask change during LOAD applies to the following frame only.
        do_frame(1'b0, 2'd0, 5'b11111, 1'b1);
        finish_frame(1'b1);
        do_frame(1'b0, 2'd3, 5'b01110, 1'b0);

        // Reset while in WAIT, with done_wait arriving afterwards.
        reset = 1'b1;
        run = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mph = 0;
        mrep = 0;
        done_wait = 1'b1;
        #1;
        check("wait reset send_it", send_it, 0);
        check("wait reset load_color", load_color, 0);
        check("wait reset busy", busy, 0);
        check("wait reset phase", phase, 0);
        @(negedge clock);
        check("wait reset stays idle", busy, 0);
        check("wait reset phase hold", phase, 0);
        done_wait = 1'b0;

        // Reset mid-LOAD, then restart from pixel 0 color 0.
        mode = 2'd3;
        enable_mask = 5'b11111;
        start_from_idle();
        ready_to_load = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        run = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("load reset load_color", load_color, 0);
        check("load reset busy", busy, 0);
        ready_to_load = 1'b0;
        @(negedge clock);
        start_from_idle();
        do_frame(1'b0, 2'd3, 5'b11111, 1'b0);
        finish_frame(1'b0);

        // Breathe at phase 33, then wrap phase 255 -> 0.
        do_reset();
        mode = 2'd2;
        enable_mask = 5'b11111;
        fast_frames(132);
        repeat (131) model_done();
        check("phase before 33", phase, mph[7:0]);
        finish_frame(1'b1);
        check("phase is 33", phase, 8'd33);
        do_frame(1'b0, 2'd2, 5'b11111, 1'b0);
        check("breathe level at 33", ll[0], 8'h1E);
        fast_frames(888);
        repeat (888) model_done();
        check("phase is 255", phase, 8'hFF);
        for (int f = 0; f < 3; f++) begin
            finish_frame(1'b1);
            do_frame(1'b0, 2'd2, 5'b11111, 1'b0);
        end
        finish_frame(1'b0);
        check("phase wrapped to 0", phase, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
